// File: rtl/morse_char_display_if.sv
// rtl/morse_char_display_if.sv - decoder-to-display character and scan-output bundle
interface morse_char_display_if;
  logic [6:0] seg_in;
  logic       char_valid;
  logic       clear;
  logic [6:0] seg_out;
  logic [3:0] an;
  logic [2:0] char_count;

  modport master (
    output seg_in, char_valid, clear,
    input  seg_out, an, char_count
  );

  modport slave (
    input  seg_in, char_valid, clear,
    output seg_out, an, char_count
  );
endinterface

// File: rtl/morse_char_display.sv
// rtl/morse_char_display.sv - 4-deep scrolling character buffer scanned onto a 4-digit common-anode display
module morse_char_display #(
  parameter int         REFRESH_DIV = 100000,
  parameter logic [6:0] BLANK_SEG   = 7'b1111111
) (
  input logic                 clk,
  input logic                 rst,
  morse_char_display_if.slave dif
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [6:0]    char_buf [4];
  logic [2:0]    count_q;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    sel;
  logic          valid_q;
  logic          cap;

  // Only the rising edge of the decoder's level-type ready flag yields a character.
  assign cap = dif.char_valid & ~valid_q;
  assign dif.char_count = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) char_buf[i] <= BLANK_SEG;
      count_q     <= 3'd0;
      refresh_cnt <= '0;
      sel         <= 2'd0;
      valid_q     <= 1'b1;
      dif.an      <= 4'b1110;
      dif.seg_out <= BLANK_SEG;
    end else begin
      valid_q <= dif.char_valid;

      if (dif.clear) begin
        for (int i = 0; i < 4; i++) char_buf[i] <= BLANK_SEG;
        count_q <= 3'd0;
      end else if (cap) begin
        char_buf[3] <= char_buf[2];
        char_buf[2] <= char_buf[1];
        char_buf[1] <= char_buf[0];
        char_buf[0] <= dif.seg_in;
        if (count_q != 3'd4) count_q <= count_q + 3'd1;
      end

      if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        sel         <= sel + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + CW'(1);
      end

      // Enable and pattern come from the same sel, so they switch together.
      dif.an      <= ~(4'b0001 << sel);
      dif.seg_out <= char_buf[sel];
    end
  end

endmodule

// File: tb/tb_morse_char_display.sv
// tb/tb_morse_char_display.sv - scoreboard bench for morse_char_display against a queue-based display model
module tb_morse_char_display;
  localparam int         R     = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  morse_char_display_if dif();

  morse_char_display #(.REFRESH_DIV(R), .BLANK_SEG(BLANK)) dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Model: newest-first list of stored characters, cycles since reset, last ready level.
  logic [6:0] m_chars[$];
  int         m_t    = 0;
  bit         m_prev = 1'b1;
  logic [3:0] last_an = 4'b1110;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic step(input bit r, input bit cv, input bit clr, input logic [6:0] s);
    exp_t e;
    int   d;
    rst            = r;
    dif.char_valid = cv;
    dif.clear      = clr;
    dif.seg_in     = s;
    @(posedge clk);
    if (r) begin
      m_chars.delete();
      m_t    = 0;
      m_prev = 1'b1;
      e.an   = 4'b1110;
      e.seg  = BLANK;
    end else begin
      d     = (m_t / R) % 4;
      e.an  = ~(4'b0001 << d);
      e.seg = (d < m_chars.size()) ? m_chars[d] : BLANK;
      if (clr) begin
        m_chars.delete();
      end else if (cv && !m_prev) begin
        m_chars.push_front(s);
        if (m_chars.size() > 4) void'(m_chars.pop_back());
      end
      m_prev = cv;
      m_t++;
    end
    e.cnt = 3'(m_chars.size());
    sb.push_back(e);
    last_an = e.an;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 7'h00);
  endtask

  task automatic capture(input logic [6:0] s, input int hold);
    for (int i = 0; i < hold; i++) step(1'b0, 1'b1, 1'b0, s);
    step(1'b0, 1'b0, 1'b0, 7'h00);
    step(1'b0, 1'b0, 1'b0, 7'h00);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("an", int'(dif.an), int'(e.an));
        chk("seg_out", int'(dif.seg_out), int'(e.seg));
        chk("char_count", int'(dif.char_count), int'(e.cnt));
        chk("an_one_low", $countones(~dif.an), 1);
      end
    end
  end

  initial begin : stim
    bit         cv_r;
    bit         r_r;
    bit         clr_r;
    logic [6:0] s_r;
    int         guard;

    // Idle scan after reset.
    step(1'b1, 1'b0, 1'b0, 7'h00);
    idle(32);

    // Ready already high across reset release is not a new character.
    step(1'b1, 1'b1, 1'b0, 7'b0001000);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 7'b0001000);
    idle(2);

    // Single pulse, then a long hold yielding one more capture only.
    step(1'b0, 1'b1, 1'b0, 7'b0001000);
    idle(20);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 7'b1100000);
    idle(4);

    // Five captures into a cleared buffer; the first one scrolls out.
    step(1'b0, 1'b0, 1'b1, 7'h00);
    capture(7'b0001000, 1);
    capture(7'b1100000, 2);
    capture(7'b0110001, 1);
    capture(7'b1000010, 3);
    capture(7'b0110000, 1);
    idle(20);

    // Clear colliding with a rising ready edge on a full buffer.
    step(1'b0, 1'b1, 1'b1, 7'b0001000);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 7'b0001000);
    idle(2);

    // Reset mid-scan with three characters held.
    capture(7'b0001000, 1);
    capture(7'b1100000, 1);
    capture(7'b0110001, 1);
    guard = 0;
    while (last_an != 4'b1011 && guard < 40) begin
      idle(1);
      guard++;
    end
    chk("reach_an_1011", int'(last_an), int'(4'b1011));
    step(1'b1, 1'b0, 1'b0, 7'h00);
    idle(24);

    // Randomized traffic.
    cv_r = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 2) == 0) cv_r = ~cv_r;
      r_r   = ($urandom_range(0, 249) == 0);
      clr_r = ($urandom_range(0, 39) == 0);
      s_r   = 7'($urandom);
      step(r_r, cv_r, clr_r, s_r);
    end
    idle(4);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_char_display.md
Name: morse_char_display

Overview:
- Downstream of the Morse decoder stage.
- Captures each decoded 7-segment character on the rising edge of the decoder's ready flag into a 4-deep shift buffer.
- Time-multiplexes the buffer onto a 4-digit common-anode display, so the last four decoded letters stay visible and scroll left as new ones arrive.
- Replaces the direct single-digit seg_out path at the top level.

Parameters:
- REFRESH_DIV, 100000: clk cycles each digit is held active before the scan advances; legal range ≥ 2.
- BLANK_SEG, 7'b1111111: segment pattern shown for an empty buffer slot (active-low, all segments off).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_in  input  7  decoded character pattern from the decoder, active-low segments
- char_valid  input  1  decoder new-input-ready flag, level signal; may stay high for many cycles
- clear  input  1  synchronous buffer clear, one or more cycles
- seg_out  output  7  registered segment drive for the currently selected digit
- an  output  4  registered digit enables, active-low, exactly one bit low at all times
- char_count  output  3  number of valid characters in the buffer, 0..4, saturating

Behaviour:
- Reset (rst=1 at a clk edge):
  - buf[0..3] = BLANK_SEG; char_count = 0.
  - Refresh counter = 0; digit select sel = 0.
  - valid_q = 1, so a char_valid already high at reset release is NOT captured.
  - an = 4'b1110; seg_out = BLANK_SEG.
  - Reset mid-scan or mid-capture discards everything.
- Edge detect:
  - valid_q <= char_valid every cycle.
  - cap = char_valid & ~valid_q.
  - A char_valid held high yields exactly one capture. The next capture requires char_valid low for at least one cycle.
- Capture, on a cycle with cap=1 and clear=0:
  - Shift left: buf[3] <= buf[2], buf[2] <= buf[1], buf[1] <= buf[0], buf[0] <= seg_in.
  - buf[0] is the newest character (rightmost digit); buf[3] is the oldest. The oldest is dropped when the buffer is full.
  - char_count <= min(char_count+1, 4).
  - seg_in is sampled in the same cycle that cap is detected.
- Clear:
  - clear=1 sets all buf to BLANK_SEG and char_count to 0.
  - Clear has priority over a simultaneous capture; that character is lost.
  - valid_q still updates during clear. A char_valid that stays high through and after clear is therefore not re-captured.
  - The scan continues unaffected.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1.
  - On the terminal count it wraps to 0 and sel <= sel+1 mod 4 (3 wraps to 0).
  - Each digit is selected for exactly REFRESH_DIV cycles; a full frame is 4*REFRESH_DIV cycles.
- Output registers, updated every cycle:
  - an <= ~(4'b0001 << sel); seg_out <= buf[sel].
  - Outputs lag sel/buf by one cycle.
  - A capture is therefore visible on seg_out one cycle after the buffer update, whenever that digit is selected.
  - an and seg_out always change in the same cycle; there are no glitch cycles with two digits enabled.
- Digit mapping: an[0] shows buf[0] (rightmost), an[3] shows buf[3] (leftmost).
- No combinational path from any input to any output.

Test Plan (REFRESH_DIV=4 for simulation):
1. Reset, then idle 32 cycles:
   - an cycles 1110 → 1101 → 1011 → 0111 → 1110, each held 4 cycles.
   - seg_out = 7'b1111111 throughout; char_count = 0.
2. Hold char_valid=1 across reset release for 10 cycles with seg_in = 7'b0001000 ('A'):
   - No capture; char_count stays 0.
3. Pulse char_valid high for 1 cycle with seg_in = 7'b0001000:
   - char_count = 1.
   - When an = 1110, seg_out = 7'b0001000; other digits blank.
   - Then hold char_valid high 20 cycles: still exactly one capture.
4. Five separate captures, codes C1..C5 (e.g. 'A', 'b', 'C', 'd', 'E'):
   - char_count saturates at 4.
   - an = 0111 shows C2, 1011 shows C3, 1101 shows C4, 1110 shows C5; C1 is dropped.
5. Assert clear in the same cycle as a char_valid rising edge, with the buffer full:
   - All digits show BLANK_SEG; char_count = 0.
   - The simultaneous character is not stored.
   - Keeping char_valid high afterwards causes no capture.
6. Assert rst for 1 cycle while an = 1011 and char_count = 3:
   - The next cycle has an = 1110, seg_out = BLANK_SEG, char_count = 0.
   - The scan restarts from digit 0 with a full 4-cycle dwell.
